// File: rtl/rr_arb8.sv
// rr_arb8 -- eight-way round-robin arbiter with a grant-index display.
//
// A grant rotates fairly among eight level-sensitive requesters. The owner
// keeps the grant until it raises done or drops its request. With timeout
// compiled in, the owner also loses the grant after HOLD_MAX cycles.
// Every release is followed by one dead cycle before the next grant.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   -> a hold counter forces release after HOLD_MAX cycles, and
//                timeout pulses in the dead cycle that follows
//   undefined -> there is no hold counter, timeout is tied 0 and HOLD_MAX
//                is only range-checked
//
// Parameters
//   HOLD_MAX   max consecutive grant cycles per owner (1..255)
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req[7:0]   request lines, bit i = requester i
//   done       owner releases grant (sampled only while granted)
//   gnt[7:0]   one-hot grant, zero when idle
//   gnt_idx    binary owner index, 0 when idle
//   gnt_valid  high iff gnt != 0
//   timeout    one-cycle pulse in the dead cycle after a forced release
//   seg0[6:0]  active-low 7-segment code of gnt_idx, blank when idle
module rr_arb8 #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout,
  output logic [6:0] seg0
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arb8: HOLD_MAX must be in 1..255");
  end

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic [7:0] r_gnt, w_gnt_nxt;
  logic [2:0] r_gnt_idx, w_gnt_idx_nxt;
  logic       r_gnt_valid, w_gnt_valid_nxt;
  logic [6:0] r_seg0, w_seg0_nxt;
  logic       w_timeout_nxt;

  logic [7:0] w_rot;
  logic [2:0] w_off;
  logic [2:0] w_pick;
  logic       w_to_hit;
  logic       w_rel;

  function automatic logic [6:0] seg_enc(input logic [2:0] v);
    logic [6:0] s;
    case (v)
      3'd0:    s = 7'b0000001;
      3'd1:    s = 7'b1001111;
      3'd2:    s = 7'b0010010;
      3'd3:    s = 7'b0000110;
      3'd4:    s = 7'b1001100;
      3'd5:    s = 7'b0100100;
      3'd6:    s = 7'b0100000;
      default: s = 7'b0001111;
    endcase
    return s;
  endfunction

  // Rotate req so that bit 0 lines up with ptr. The lowest set bit of the
  // rotated vector is then the first requester at or after ptr.
  always_comb begin
    w_rot = 8'({req, req} >> r_ptr);
    w_off = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (w_rot[j]) w_off = 3'(j);
    end
  end

  assign w_pick = r_ptr + w_off;  // 3-bit add wraps mod 8

`ifdef ARB_TIMEOUT_EN
  localparam int HCW = $clog2(HOLD_MAX + 1);

  logic [HCW-1:0] r_hold_cnt;
  logic           r_timeout;

  // hold_cnt is HOLD_MAX-1 in the last allowed grant cycle.
  assign w_to_hit = (r_hold_cnt == HCW'(HOLD_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst)                                  r_hold_cnt <= '0;
    else if (r_state == S_IDLE)               r_hold_cnt <= '0;
    else if (!w_rel && (r_hold_cnt != '1))    r_hold_cnt <= r_hold_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_timeout <= 1'b0;
    else     r_timeout <= w_timeout_nxt;
  end

  assign timeout = r_timeout;
`else
  assign w_to_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  // A release happens on done, on withdrawal by the owner, or on timeout.
  // All three can coincide, but they still produce a single release.
  assign w_rel = done | ~req[r_gnt_idx] | w_to_hit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (|req) w_state_nxt = S_GRANT;
      S_GRANT: if (w_rel) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs and the pointer
  always_comb begin
    w_ptr_nxt       = r_ptr;
    w_gnt_nxt       = r_gnt;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_gnt_valid_nxt = r_gnt_valid;
    w_seg0_nxt      = r_seg0;
    w_timeout_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_gnt_nxt       = 8'b1 << w_pick;
          w_gnt_idx_nxt   = w_pick;
          w_gnt_valid_nxt = 1'b1;
          w_seg0_nxt      = seg_enc(w_pick);
        end
      end
      S_GRANT: begin
        if (w_rel) begin
          w_ptr_nxt       = r_gnt_idx + 3'd1;
          w_gnt_nxt       = 8'h00;
          w_gnt_idx_nxt   = 3'd0;
          w_gnt_valid_nxt = 1'b0;
          w_seg0_nxt      = SEG_BLANK;
          w_timeout_nxt   = w_to_hit;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= 3'd0;
      r_gnt       <= 8'h00;
      r_gnt_idx   <= 3'd0;
      r_gnt_valid <= 1'b0;
      r_seg0      <= SEG_BLANK;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_seg0      <= w_seg0_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign seg0      = r_seg0;

endmodule
